// File: rtl/sdram_burst_arbiter.sv
// Two-host burst arbiter for one SDRAM port. The VGA reader has priority, and a starvation guard protects the stream writer.
// Grants are registered and drive sd_* one cycle after the request. The granted host sees sd_waitrequest; the other host is stalled.
module sdram_burst_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int BW         = 5,
    parameter int MAX_CONSEC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vga_read,
    input  logic [AW-1:0]   vga_address,
    input  logic [BW-1:0]   vga_burstcount,
    output logic [DW-1:0]   vga_readdata,
    output logic            vga_readdatavalid,
    output logic            vga_waitrequest,
    input  logic            st_write,
    input  logic [AW-1:0]   st_address,
    input  logic [BW-1:0]   st_burstcount,
    input  logic [DW-1:0]   st_writedata,
    input  logic [DW/8-1:0] st_byteenable,
    output logic            st_waitrequest,
    output logic            sd_read,
    output logic            sd_write,
    output logic [AW-1:0]   sd_address,
    output logic [BW-1:0]   sd_burstcount,
    output logic [DW-1:0]   sd_writedata,
    output logic [DW/8-1:0] sd_byteenable,
    input  logic [DW-1:0]   sd_readdata,
    input  logic            sd_readdatavalid,
    input  logic            sd_waitrequest,
    output logic            busy,
    output logic            rd_error
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] CMAX = MAX_CONSEC[CW-1:0];
    localparam logic [CW-1:0] C1   = 1;
    localparam logic [BW-1:0] ONE  = 1;

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] rd_len, wr_len, rd_cnt, wr_cnt;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] consec;
    logic          armed;
    logic          starve, grant_rd, grant_wr, rd_beat, wr_beat;
    logic [BW-1:0] vga_len, st_len;

    assign vga_len = (vga_burstcount == '0) ? ONE : vga_burstcount;
    assign st_len  = (st_burstcount == '0) ? ONE : st_burstcount;
    assign starve  = st_write && (consec == CMAX);
    assign rd_beat = sd_readdatavalid && (state == RD_CMD || state == RD_DATA);
    assign wr_beat = (state == WR_BURST) && st_write && !sd_waitrequest;

    assign vga_readdata = sd_readdata;
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt         = state;
        grant_rd          = 1'b0;
        grant_wr          = 1'b0;
        sd_read           = 1'b0;
        sd_write          = 1'b0;
        sd_address        = '0;
        sd_burstcount     = '0;
        sd_writedata      = '0;
        sd_byteenable     = '0;
        vga_waitrequest   = 1'b1;
        st_waitrequest    = 1'b1;
        vga_readdatavalid = 1'b0;
        case (state)
            IDLE: begin
                if (vga_read && !starve) begin
                    grant_rd  = 1'b1;
                    state_nxt = RD_CMD;
                end else if (st_write) begin
                    grant_wr  = 1'b1;
                    state_nxt = WR_BURST;
                end
            end
            RD_CMD: begin
                sd_read           = 1'b1;
                sd_address        = cmd_addr;
                sd_burstcount     = rd_len;
                vga_waitrequest   = sd_waitrequest;
                vga_readdatavalid = sd_readdatavalid;
                if (!sd_waitrequest)
                    state_nxt = RD_DATA;
            end
            RD_DATA: begin
                vga_readdatavalid = sd_readdatavalid;
                // The second term covers bursts whose data all arrived while the command was still stalled.
                if ((sd_readdatavalid && rd_cnt == rd_len - ONE) || rd_cnt == rd_len)
                    state_nxt = IDLE;
            end
            WR_BURST: begin
                sd_write       = st_write;
                sd_writedata   = st_writedata;
                sd_byteenable  = st_byteenable;
                sd_address     = cmd_addr;
                sd_burstcount  = wr_len;
                st_waitrequest = sd_waitrequest;
                if (wr_beat && wr_cnt == wr_len - ONE)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rd_len   <= '0;
            wr_len   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            cmd_addr <= '0;
            consec   <= '0;
            armed    <= 1'b0;
            rd_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_rd) begin
                rd_len   <= vga_len;
                cmd_addr <= vga_address;
                rd_cnt   <= '0;
                armed    <= 1'b1;
                consec   <= !st_write ? '0 : (consec == CMAX) ? CMAX : consec + C1;
            end else if (rd_beat) begin
                rd_cnt <= rd_cnt + ONE;
            end
            if (grant_wr) begin
                wr_len   <= st_len;
                cmd_addr <= st_address;
                wr_cnt   <= '0;
                armed    <= 1'b1;
                consec   <= '0;
            end else if (wr_beat) begin
                wr_cnt <= wr_cnt + ONE;
            end
            // Beats that arrive after a reset-abandoned burst are ignored until the next grant.
            if (armed && sd_readdatavalid && (state == IDLE || state == WR_BURST))
                rd_error <= 1'b1;
        end
    end

endmodule
